// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: stage instructions and destination
// registers in, freeze/flush and mult/div sequencing controls out.
interface hazard_ctrl_if;
  logic [31:0] Instr_D;
  logic [31:0] Instr_E;
  logic [31:0] Instr_M;
  logic [4:0]  A3E;
  logic [4:0]  A3M;
  logic        DStall;
  logic        EClr;
  logic        MDUStart;
  logic        MDUBusy;

  // Pipeline datapath side: presents stage contents, consumes controls.
  modport master (
    output Instr_D, Instr_E, Instr_M, A3E, A3M,
    input  DStall, EClr, MDUStart, MDUBusy
  );

  // Hazard controller side.
  modport slave (
    input  Instr_D, Instr_E, Instr_M, A3E, A3M,
    output DStall, EClr, MDUStart, MDUBusy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS pipeline.
// Compares D-stage sources against E/M destinations with Tuse/Tnew rules and
// sequences the multi-cycle mult/div unit with a busy down-counter.
// Optional feature: define HAZARD_MDU_STALL_EN to build the mult/div counter
// and its stall; when undefined MDUStart/MDUBusy are tied low and only the
// data-hazard stall remains.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input logic         Clk,
  input logic         Reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [3:0] {
    ClsNop,
    ClsCalR,
    ClsShift,
    ClsCalI,
    ClsLui,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJr,
    ClsJal,
    ClsJ,
    ClsMd,
    ClsMf,
    ClsMt
  } instr_cls_e;

  // Tuse is 0..2; TuseInf marks a register that is not read, so it never
  // compares below any Tnew (max 2).
  localparam logic [1:0] TuseInf = 2'd3;

  // Opcode / funct decode into instruction classes. All-zero words and
  // unrecognised encodings are nops.
  function automatic instr_cls_e decode(input logic [31:0] instr);
    instr_cls_e cls;
    logic [5:0] op;
    logic [5:0] fn;
    op  = instr[31:26];
    fn  = instr[5:0];
    cls = ClsNop;
    if (instr != 32'd0) begin
      case (op)
        6'h00: begin
          case (fn)
            6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b: cls = ClsCalR;
            6'h00:                                   cls = ClsShift;
            6'h08:                                   cls = ClsJr;
            6'h18, 6'h19, 6'h1a, 6'h1b:              cls = ClsMd;
            6'h10, 6'h12:                            cls = ClsMf;
            6'h11, 6'h13:                            cls = ClsMt;
            default:                                 cls = ClsNop;
          endcase
        end
        6'h0d, 6'h09: cls = ClsCalI;
        6'h0f:        cls = ClsLui;
        6'h23:        cls = ClsLoad;
        6'h2b:        cls = ClsStore;
        6'h04, 6'h05: cls = ClsBranch;
        6'h03:        cls = ClsJal;
        6'h02:        cls = ClsJ;
        default:      cls = ClsNop;
      endcase
    end
    return cls;
  endfunction

  instr_cls_e cls_d, cls_e, cls_m;
  logic [1:0] tuse_rs, tuse_rt;
  logic [1:0] tnew_e, tnew_m;
  logic [4:0] rs_d, rt_d;
  logic       stall_rs, stall_rt, stall_mdu;
  logic       mdu_start, mdu_busy;

  assign rs_d = hz.Instr_D[25:21];
  assign rt_d = hz.Instr_D[20:16];

  // Classify each stage and derive Tuse (D) and Tnew (E, M).
  always_comb begin
    cls_d   = decode(hz.Instr_D);
    cls_e   = decode(hz.Instr_E);
    cls_m   = decode(hz.Instr_M);
    tuse_rs = TuseInf;
    tuse_rt = TuseInf;
    tnew_e  = 2'd0;
    tnew_m  = 2'd0;

    case (cls_d)
      ClsBranch: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      ClsJr:     tuse_rs = 2'd0;
      ClsCalR, ClsMd: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
      end
      ClsShift:  tuse_rt = 2'd1;
      ClsCalI, ClsLoad, ClsMt: tuse_rs = 2'd1;
      ClsStore: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      default: ;
    endcase

    case (cls_e)
      ClsLoad:                                 tnew_e = 2'd2;
      ClsCalR, ClsShift, ClsCalI, ClsLui, ClsMf: tnew_e = 2'd1;
      default:                                 tnew_e = 2'd0;
    endcase

    if (cls_m == ClsLoad) begin
      tnew_m = 2'd1;
    end
  end

  // Data hazard: a source still awaited from E or M after its use point.
  always_comb begin
    stall_rs = (rs_d != 5'd0) &&
               (((rs_d == hz.A3E) && (tuse_rs < tnew_e)) ||
                ((rs_d == hz.A3M) && (tuse_rs < tnew_m)));
    stall_rt = (rt_d != 5'd0) &&
               (((rt_d == hz.A3E) && (tuse_rt < tnew_e)) ||
                ((rt_d == hz.A3M) && (tuse_rt < tnew_m)));
  end

`ifdef HAZARD_MDU_STALL_EN
  localparam logic [3:0] MultCnt = 4'(MULT_CYC);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYC);

  logic [3:0] cnt_q, cnt_d;
  logic       md_d;

  assign md_d = (cls_d == ClsMd) || (cls_d == ClsMf) || (cls_d == ClsMt);

  // Launch only from idle; an md reaching E while busy is ignored.
  always_comb begin
    mdu_busy  = (cnt_q != 4'd0);
    mdu_start = (cls_e == ClsMd) && (cnt_q == 4'd0);
    stall_mdu = md_d && (mdu_busy || mdu_start);
  end

  // Counter next state: load on launch (funct bit 1 separates div from mult),
  // otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (mdu_start) begin
      cnt_d = hz.Instr_E[1] ? DivCnt : MultCnt;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Busy counter register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_mdu;

  assign unused_mdu = ^{Clk, 4'(MULT_CYC), 4'(DIV_CYC)};

  // No mult/div sequencing in this build.
  always_comb begin
    mdu_busy  = 1'b0;
    mdu_start = 1'b0;
    stall_mdu = 1'b0;
  end
`endif

  // Outputs are held low while Reset is asserted.
  always_comb begin
    hz.DStall   = 1'b0;
    hz.EClr     = 1'b0;
    hz.MDUStart = 1'b0;
    hz.MDUBusy  = 1'b0;
    if (!Reset) begin
      hz.DStall   = stall_rs | stall_rt | stall_mdu;
      hz.EClr     = stall_rs | stall_rt | stall_mdu;
      hz.MDUStart = mdu_start;
      hz.MDUBusy  = mdu_busy;
    end
  end

endmodule
